// File: rtl/pump_pkg.sv
// Shared types and valve-pattern rule for the N-valve peristaltic pump sequencer.
package pump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pump_state_e;

  localparam logic AIR_CLOSED = 1'b1;
  localparam logic AIR_OPEN   = 1'b0;

  // Air line of valve idx in phase ph: an open window travels along the chain, last phase seals all.
  function automatic logic valve_air(input int unsigned ph, input logic dir,
                                     input int unsigned n, input int unsigned idx);
    int unsigned v;
    v = dir ? (n - 1 - idx) : idx;
    if (ph >= 2 * n - 1) return AIR_CLOSED;
    if ((v == ph / 2) || (v == (ph + 1) / 2)) return AIR_OPEN;
    return AIR_CLOSED;
  endfunction

endpackage

// File: rtl/pump_phase_decode.sv
// Combinational phase/direction to valve air-vector decoder.
module pump_phase_decode
  import pump_pkg::*;
#(
  parameter int NUM_VALVES = 3,
  parameter int PH_W       = $clog2(2 * NUM_VALVES)
) (
  input  logic [PH_W-1:0]       phase,
  input  logic                  dir,
  output logic [NUM_VALVES-1:0] air
);

  always_comb begin
    air = '0;
    for (int i = 0; i < NUM_VALVES; i++) begin
      air[i] = valve_air(32'(phase), dir, NUM_VALVES, unsigned'(i));
    end
  end

endmodule

// File: rtl/pumpn_seq_ctrl.sv
// N-valve peristaltic pump sequencer: travelling open window with dwell, stroke count, abort and flush.
module pumpn_seq_ctrl
  import pump_pkg::*;
#(
  parameter int NUM_VALVES = 3,
  parameter int DWELL_W    = 16,
  parameter int CNT_W      = 16,
  parameter int PH_W       = $clog2(2 * NUM_VALVES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [CNT_W-1:0]      strokes,
  input  logic                  abort,
  input  logic                  flush,
  output logic [NUM_VALVES-1:0] air,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      strokes_done,
  output logic [PH_W-1:0]       phase
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(2 * NUM_VALVES - 1);

  pump_state_e           state, state_nx;
  logic                  dir_q, dir_nx;
  logic [DWELL_W-1:0]    dwell_q, dwell_cnt, dwell_max;
  logic [CNT_W-1:0]      strokes_q, strokes_inc;
  logic [PH_W-1:0]       phase_nx;
  logic [NUM_VALVES-1:0] pat_nx, air_nx;
  logic                  launch, phase_end, stroke_end, run_end;

  assign launch      = (state == IDLE) && start;
  assign dwell_max   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign phase_end   = (dwell_cnt == dwell_max - DWELL_W'(1));
  assign stroke_end  = phase_end && (phase == LAST_PH);
  assign strokes_inc = strokes_done + CNT_W'(1);
  assign run_end     = stroke_end && (strokes_q != '0) && (strokes_inc == strokes_q);
  assign busy        = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
               else if (flush) state_nx = FLUSH;
      FLUSH:   if (!flush) state_nx = IDLE;
      RUN:     if (abort || run_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Air is registered, so the decoder looks at the phase and direction of the coming cycle.
  always_comb begin
    phase_nx = phase;
    dir_nx   = launch ? dir : dir_q;
    if (launch || (busy && abort)) phase_nx = '0;
    else if (busy && phase_end) phase_nx = stroke_end ? '0 : phase + PH_W'(1);
  end

  pump_phase_decode #(
    .NUM_VALVES(NUM_VALVES),
    .PH_W      (PH_W)
  ) u_decode (
    .phase(phase_nx),
    .dir  (dir_nx),
    .air  (pat_nx)
  );

  always_comb begin
    air_nx = {NUM_VALVES{AIR_CLOSED}};
    if (state_nx == RUN) air_nx = pat_nx;
    else if (state_nx == FLUSH) air_nx = {NUM_VALVES{AIR_OPEN}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      air          <= {NUM_VALVES{AIR_CLOSED}};
      done         <= 1'b0;
      aborted      <= 1'b0;
      strokes_done <= '0;
      phase        <= '0;
      dir_q        <= 1'b0;
      dwell_q      <= '0;
      strokes_q    <= '0;
      dwell_cnt    <= '0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      air     <= air_nx;
      done    <= busy && !abort && run_end;
      aborted <= busy && abort;
      if (launch) begin
        dir_q        <= dir;
        dwell_q      <= dwell;
        strokes_q    <= strokes;
        strokes_done <= '0;
        dwell_cnt    <= '0;
      end else if (busy && !abort) begin
        dwell_cnt <= phase_end ? '0 : dwell_cnt + DWELL_W'(1);
        if (stroke_end) strokes_done <= strokes_inc;
      end
    end
  end

endmodule

// File: tb/tb_pumpn_seq_ctrl.sv
// Self-checking bench for pumpn_seq_ctrl against a cycle-indexed behavioural model.
module tb_pumpn_seq_ctrl;

  localparam int N       = 3;
  localparam int DWELL_W = 16;
  localparam int CNT_W   = 16;
  localparam int PH_W    = $clog2(2 * N);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               dir = 1'b0;
  logic               abort = 1'b0;
  logic               flush = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [CNT_W-1:0]   strokes = '0;
  logic [N-1:0]       air;
  logic               busy, done, aborted;
  logic [CNT_W-1:0]   strokes_done;
  logic [PH_W-1:0]    phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pumpn_seq_ctrl #(
    .NUM_VALVES(N),
    .DWELL_W   (DWELL_W),
    .CNT_W     (CNT_W),
    .PH_W      (PH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dir         (dir),
    .dwell       (dwell),
    .strokes     (strokes),
    .abort       (abort),
    .flush       (flush),
    .air         (air),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .strokes_done(strokes_done),
    .phase       (phase)
  );

  // Open set of phase p: valves j with 2j in {p-1, p, p+1}, none in the seal phase; reverse mirrors j.
  function automatic logic [N-1:0] exp_air(input int p, input bit d);
    logic [N-1:0] a;
    int j;
    a = '1;
    if (p != 2 * N - 1) begin
      for (int i = 0; i < N; i++) begin
        j = d ? (N - 1 - i) : i;
        if ((2 * j == p) || (2 * j == p - 1) || (2 * j == p + 1)) a[i] = 1'b0;
      end
    end
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input bit r_dir, input int r_dwell, input int r_strokes);
    int d, total, p, sd;
    d     = (r_dwell == 0) ? 1 : r_dwell;
    total = 2 * N * d * r_strokes;
    start   = 1'b1;
    dir     = r_dir;
    dwell   = DWELL_W'(r_dwell);
    strokes = CNT_W'(r_strokes);
    step();
    start   = 1'b0;
    dir     = 1'($urandom_range(0, 1));
    dwell   = DWELL_W'($urandom_range(0, 9));
    strokes = CNT_W'($urandom_range(0, 9));
    for (int k = 1; k <= total; k++) begin
      p  = ((k - 1) / d) % (2 * N);
      sd = (k - 1) / (2 * N * d);
      checks++;
      if (air !== exp_air(p, r_dir)) begin
        errors++;
        $display("[TB] FAIL run_air cyc%0d got %b want %b", k, air, exp_air(p, r_dir));
      end
      checks++;
      if (phase !== PH_W'(p)) begin
        errors++;
        $display("[TB] FAIL run_phase cyc%0d got %0d want %0d", k, phase, p);
      end
      checks++;
      if (strokes_done !== CNT_W'(sd)) begin
        errors++;
        $display("[TB] FAIL run_strokes cyc%0d got %0d want %0d", k, strokes_done, sd);
      end
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL run_busy_done cyc%0d got %b want 10", k, {busy, done});
      end
      step();
    end
    checks++;
    if ({busy, done, aborted} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL end_flags cyc%0d got %b want 010", total + 1, {busy, done, aborted});
    end
    checks++;
    if (air !== '1) begin
      errors++;
      $display("[TB] FAIL end_air got %b want 111", air);
    end
    checks++;
    if (strokes_done !== CNT_W'(r_strokes)) begin
      errors++;
      $display("[TB] FAIL end_strokes got %0d want %0d", strokes_done, r_strokes);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL post_done got %b want 00", {busy, done});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({air, busy, done, aborted, strokes_done, phase} !== {3'b111, 3'b000, CNT_W'(0), PH_W'(0)}) begin
      errors++;
      $display("[TB] FAIL reset got air=%b b/d/a=%b sd=%0d ph=%0d want 111 000 0 0",
               air, {busy, done, aborted}, strokes_done, phase);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_forward();
    do_run(1'b0, 2, 1);
  endtask

  task automatic test_reverse();
    do_run(1'b1, 2, 1);
  endtask

  task automatic test_dwell_zero();
    do_run(1'b0, 0, 2);
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 6; r++) begin
      do_run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_abort();
    bit d;
    d = 1'($urandom_range(0, 1));
    start = 1'b1; dir = d; dwell = DWELL_W'(1); strokes = CNT_W'(0);
    step();
    start = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      checks++;
      if ((air !== exp_air((k - 1) % (2 * N), d)) || done || aborted) begin
        errors++;
        $display("[TB] FAIL cont_run cyc%0d air %b want %b done=%b aborted=%b",
                 k, air, exp_air((k - 1) % (2 * N), d), done, aborted);
      end
      if (k < 22) step();
    end
    checks++;
    if ((phase !== PH_W'(3)) || (strokes_done !== CNT_W'(3))) begin
      errors++;
      $display("[TB] FAIL pre_abort got ph=%0d sd=%0d want 3 3", phase, strokes_done);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({air, busy, done, aborted} !== 6'b111001 || strokes_done !== CNT_W'(3)) begin
      errors++;
      $display("[TB] FAIL abort_exit got air=%b b/d/a=%b sd=%0d want 111 001 3",
               air, {busy, done, aborted}, strokes_done);
    end
    step();
    checks++;
    if ({busy, done, aborted} !== 3'b000 || strokes_done !== CNT_W'(3)) begin
      errors++;
      $display("[TB] FAIL abort_after got b/d/a=%b sd=%0d want 000 3", {busy, done, aborted}, strokes_done);
    end
    // Abort landing on the final phase of the final stroke must win over completion.
    start = 1'b1; dir = 1'b0; dwell = DWELL_W'(1); strokes = CNT_W'(1);
    step();
    start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, done, aborted} !== 3'b001 || strokes_done !== CNT_W'(0)) begin
      errors++;
      $display("[TB] FAIL abort_prio got b/d/a=%b sd=%0d want 001 0", {busy, done, aborted}, strokes_done);
    end
    step();
    checks++;
    if ({busy, done, aborted} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_prio_after got %b want 000", {busy, done, aborted});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({air, busy, aborted} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL abort_idle got air=%b busy=%b aborted=%b want 111 0 0", air, busy, aborted);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    checks++;
    if ({air, busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_on got air=%b busy=%b want 000 0", air, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({air, aborted} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_abort got air=%b aborted=%b want 000 0", air, aborted);
    end
    flush = 1'b0;
    step();
    checks++;
    if ({air, busy} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL flush_off got air=%b busy=%b want 111 0", air, busy);
    end
    flush = 1'b1;
    do_run(1'b0, 1, 1);
    checks++;
    if (air !== 3'b000) begin
      errors++;
      $display("[TB] FAIL flush_after_run got %b want 000", air);
    end
    flush = 1'b0;
    step();
    checks++;
    if (air !== 3'b111) begin
      errors++;
      $display("[TB] FAIL flush_release got %b want 111", air);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; dir = 1'b0; dwell = DWELL_W'(1); strokes = CNT_W'(1);
    repeat (7) step();
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL b2b_first_done got %b want 01", {busy, done});
    end
    step();
    start = 1'b0;
    checks++;
    if ({busy, done, air, phase, strokes_done} !== {2'b10, 3'b110, PH_W'(0), CNT_W'(0)}) begin
      errors++;
      $display("[TB] FAIL b2b_restart got b/d=%b air=%b ph=%0d sd=%0d want 10 110 0 0",
               {busy, done}, air, phase, strokes_done);
    end
    repeat (6) step();
    checks++;
    if ({busy, done} !== 2'b01 || strokes_done !== CNT_W'(1)) begin
      errors++;
      $display("[TB] FAIL b2b_second_done got b/d=%b sd=%0d want 01 1", {busy, done}, strokes_done);
    end
    step();
  endtask

  task automatic test_async_reset();
    start = 1'b1; dir = 1'b0; dwell = DWELL_W'(2); strokes = CNT_W'(2);
    step();
    start = 1'b0;
    repeat (4) step();
    checks++;
    if ((phase !== PH_W'(2)) || (air !== 3'b101)) begin
      errors++;
      $display("[TB] FAIL pre_reset got ph=%0d air=%b want 2 101", phase, air);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({air, busy, done, aborted, strokes_done, phase} !== {3'b111, 3'b000, CNT_W'(0), PH_W'(0)}) begin
      errors++;
      $display("[TB] FAIL async_reset got air=%b b/d/a=%b sd=%0d ph=%0d want 111 000 0 0",
               air, {busy, done, aborted}, strokes_done, phase);
    end
    #2 rst_n = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if ({air, busy, done, aborted} !== 6'b111000) begin
        errors++;
        $display("[TB] FAIL post_reset got air=%b b/d/a=%b want 111 000", air, {busy, done, aborted});
      end
    end
    do_run(1'b1, 1, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_dwell_zero();
    test_random_runs();
    test_abort();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
